// File: rtl/display_signal_runtime_if.sv
// Timing-generator bus: run-time mode request in, pixel timing and status out.
// The master side programs modes and consumes pixels; the slave side is the generator.
interface display_signal_runtime_if #(
  parameter int W = 13
);
  logic         i_cfg_load;
  logic [W-1:0] i_h_res;
  logic [W-1:0] i_h_fp;
  logic [W-1:0] i_h_sync;
  logic [W-1:0] i_h_bp;
  logic [W-1:0] i_v_res;
  logic [W-1:0] i_v_fp;
  logic [W-1:0] i_v_sync;
  logic [W-1:0] i_v_bp;
  logic         i_h_pol;
  logic         i_v_pol;
  logic [2:0]   o_hve;
  logic [W-1:0] o_x;
  logic [W-1:0] o_y;
  logic         o_line_start;
  logic         o_frame_start;
  logic [15:0]  o_frame_count;
  logic         o_cfg_pending;
  logic         o_cfg_error;
  logic         o_dbg_state;

  // i_cfg_load is a single-cycle strobe with no ready: every load is either
  // accepted (shadowed or applied) or rejected with an o_cfg_error pulse.
  modport master (
    output i_cfg_load, i_h_res, i_h_fp, i_h_sync, i_h_bp,
           i_v_res, i_v_fp, i_v_sync, i_v_bp, i_h_pol, i_v_pol,
    input  o_hve, o_x, o_y, o_line_start, o_frame_start, o_frame_count,
           o_cfg_pending, o_cfg_error, o_dbg_state
  );

  modport slave (
    input  i_cfg_load, i_h_res, i_h_fp, i_h_sync, i_h_bp,
           i_v_res, i_v_fp, i_v_sync, i_v_bp, i_h_pol, i_v_pol,
    output o_hve, o_x, o_y, o_line_start, o_frame_start, o_frame_count,
           o_cfg_pending, o_cfg_error, o_dbg_state
  );
endinterface

// File: rtl/display_signal_runtime.sv
// Run-time reprogrammable video timing generator: mode changes land only on frame
// boundaries; outputs are registered and describe the same pixel.
module display_signal_runtime #(
  parameter int W          = 13,
  parameter int RST_H_RES  = 1024,
  parameter int RST_H_FP   = 48,
  parameter int RST_H_SYNC = 32,
  parameter int RST_H_BP   = 80,
  parameter int RST_V_RES  = 768,
  parameter int RST_V_FP   = 3,
  parameter int RST_V_SYNC = 4,
  parameter int RST_V_BP   = 19,
  parameter bit RST_H_POL  = 1'b1,
  parameter bit RST_V_POL  = 1'b0
) (
  input logic                     i_pixel_clk,
  input logic                     i_reset,
  display_signal_runtime_if.slave bus
);

  typedef struct packed {
    logic [W-1:0] h_res;
    logic [W-1:0] h_fp;
    logic [W-1:0] h_sync;
    logic [W-1:0] h_bp;
    logic [W-1:0] v_res;
    logic [W-1:0] v_fp;
    logic [W-1:0] v_sync;
    logic [W-1:0] v_bp;
    logic         h_pol;
    logic         v_pol;
  } timing_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam timing_t RST_TIMING = '{
    h_res: W'(RST_H_RES), h_fp: W'(RST_H_FP), h_sync: W'(RST_H_SYNC), h_bp: W'(RST_H_BP),
    v_res: W'(RST_V_RES), v_fp: W'(RST_V_FP), v_sync: W'(RST_V_SYNC), v_bp: W'(RST_V_BP),
    h_pol: RST_H_POL, v_pol: RST_V_POL
  };
  localparam logic [W+1:0] MAX_TOTAL = (W+2)'((1 << W) - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_running;
  timing_t      r_act;
  timing_t      r_shadow;
  logic         r_pending;
  logic [W-1:0] r_h;
  logic [W-1:0] r_v;
  timing_t      w_req;
  timing_t      w_act_nxt;
  logic [W+1:0] w_req_h_tot;
  logic [W+1:0] w_req_v_tot;
  logic         w_req_ok;
  logic         w_load_ok;
  logic         w_load_bad;
  logic [W-1:0] w_h_tot;
  logic [W-1:0] w_v_tot;
  logic         w_h_last;
  logic         w_v_last;
  logic         w_frame_end;
  logic [W-1:0] w_nh;
  logic [W-1:0] w_nv;
  logic         w_de;
  logic         w_hs_act;
  logic         w_vs_act;

  // Idle only for the first edge after reset, so that edge presents pixel (0,0).
  always_ff @(posedge i_pixel_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_running = (r_state == ST_RUN);
  end

  assign w_req = '{
    h_res: bus.i_h_res, h_fp: bus.i_h_fp, h_sync: bus.i_h_sync, h_bp: bus.i_h_bp,
    v_res: bus.i_v_res, v_fp: bus.i_v_fp, v_sync: bus.i_v_sync, v_bp: bus.i_v_bp,
    h_pol: bus.i_h_pol, v_pol: bus.i_v_pol
  };

  // Totals are formed two bits wider so an oversized request cannot wrap into range.
  assign w_req_h_tot = (W+2)'(w_req.h_res) + (W+2)'(w_req.h_fp)
                     + (W+2)'(w_req.h_sync) + (W+2)'(w_req.h_bp);
  assign w_req_v_tot = (W+2)'(w_req.v_res) + (W+2)'(w_req.v_fp)
                     + (W+2)'(w_req.v_sync) + (W+2)'(w_req.v_bp);
  assign w_req_ok    = (w_req.h_res != '0) && (w_req.h_sync != '0)
                    && (w_req.v_res != '0) && (w_req.v_sync != '0)
                    && (w_req_h_tot <= MAX_TOTAL) && (w_req_v_tot <= MAX_TOTAL);
  assign w_load_ok   = bus.i_cfg_load && w_req_ok;
  assign w_load_bad  = bus.i_cfg_load && !w_req_ok;

  assign w_h_tot     = r_act.h_res + r_act.h_fp + r_act.h_sync + r_act.h_bp;
  assign w_v_tot     = r_act.v_res + r_act.v_fp + r_act.v_sync + r_act.v_bp;
  assign w_h_last    = (r_h == w_h_tot - W'(1));
  assign w_v_last    = (r_v == w_v_tot - W'(1));
  assign w_frame_end = w_running && w_h_last && w_v_last;

  always_comb begin
    w_act_nxt = r_act;
    if (w_frame_end) begin
      if (w_load_ok)      w_act_nxt = w_req;
      else if (r_pending) w_act_nxt = r_shadow;
    end
  end

  always_comb begin
    w_nh = '0;
    w_nv = '0;
    if (w_running) begin
      if (w_h_last) begin
        w_nh = '0;
        w_nv = w_v_last ? '0 : r_v + W'(1);
      end else begin
        w_nh = r_h + W'(1);
        w_nv = r_v;
      end
    end
  end

  // Decode the upcoming pixel against the timing that will be in force for it.
  assign w_de     = (w_nh < w_act_nxt.h_res) && (w_nv < w_act_nxt.v_res);
  assign w_hs_act = (w_nh >= w_act_nxt.h_res + w_act_nxt.h_fp)
                 && (w_nh <  w_act_nxt.h_res + w_act_nxt.h_fp + w_act_nxt.h_sync);
  assign w_vs_act = (w_nv >= w_act_nxt.v_res + w_act_nxt.v_fp)
                 && (w_nv <  w_act_nxt.v_res + w_act_nxt.v_fp + w_act_nxt.v_sync);

  always_ff @(posedge i_pixel_clk or posedge i_reset) begin
    if (i_reset) begin
      r_act             <= RST_TIMING;
      r_shadow          <= RST_TIMING;
      r_pending         <= 1'b0;
      r_h               <= '0;
      r_v               <= '0;
      bus.o_hve         <= {1'b0, ~RST_V_POL, ~RST_H_POL};
      bus.o_line_start  <= 1'b0;
      bus.o_frame_start <= 1'b0;
      bus.o_frame_count <= '0;
      bus.o_cfg_error   <= 1'b0;
    end else begin
      r_act             <= w_act_nxt;
      r_h               <= w_nh;
      r_v               <= w_nv;
      bus.o_hve         <= {w_de,
                            w_vs_act ? w_act_nxt.v_pol : ~w_act_nxt.v_pol,
                            w_hs_act ? w_act_nxt.h_pol : ~w_act_nxt.h_pol};
      bus.o_line_start  <= (w_nh == '0);
      bus.o_frame_start <= (w_nh == '0) && (w_nv == '0);
      bus.o_cfg_error   <= w_load_bad;
      if (w_frame_end) begin
        bus.o_frame_count <= bus.o_frame_count + 16'd1;
        r_pending         <= 1'b0;
      end else if (w_load_ok) begin
        r_shadow          <= w_req;
        r_pending         <= 1'b1;
      end
    end
  end

  assign bus.o_x           = r_h;
  assign bus.o_y           = r_v;
  assign bus.o_cfg_pending = r_pending;
  assign bus.o_dbg_state   = r_state;

endmodule

// File: tb/tb_display_signal_runtime.sv
// Directed bench for display_signal_runtime: default mode, run-time mode changes,
// rejected loads, async reset with the clock stopped and frame counter wrap.
module tb_display_signal_runtime;
  localparam int W = 13;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  display_signal_runtime_if #(.W(W)) bus ();

  display_signal_runtime #(.W(W)) dut (
    .i_pixel_clk (clk),
    .i_reset     (rst),
    .bus         (bus)
  );

  always #1 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d (at x=%0d y=%0d)", tag, obs, exp, bus.o_x, bus.o_y);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_pix(input int ex, input int ey, input logic [2:0] ehve);
    chk("x", 32'(bus.o_x), 32'(ex));
    chk("y", 32'(bus.o_y), 32'(ey));
    chk("hve", 32'(bus.o_hve), 32'(ehve));
  endtask

  task automatic wait_xy(input int ex, input int ey, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (32'(bus.o_x) == 32'(ex) && 32'(bus.o_y) == 32'(ey)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("wait_xy_reached", 32'(found), 32'd1);
  endtask

  task automatic set_mode(input int hr, input int hf, input int hs, input int hb,
                          input int vr, input int vf, input int vs, input int vb,
                          input logic hp, input logic vp);
    bus.i_h_res = W'(hr); bus.i_h_fp = W'(hf); bus.i_h_sync = W'(hs); bus.i_h_bp = W'(hb);
    bus.i_v_res = W'(vr); bus.i_v_fp = W'(vf); bus.i_v_sync = W'(vs); bus.i_v_bp = W'(vb);
    bus.i_h_pol = hp; bus.i_v_pol = vp;
  endtask

  // Strobe for one cycle; returns at the following negedge with load low.
  task automatic pulse_load();
    bus.i_cfg_load = 1'b1;
    step();
    bus.i_cfg_load = 1'b0;
  endtask

  initial begin
    bus.i_cfg_load = 1'b0;
    set_mode(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Reset values while held in reset
    #3;
    chk_pix(0, 0, 3'b010);
    chk("rst_line_start", 32'(bus.o_line_start), 0);
    chk("rst_frame_start", 32'(bus.o_frame_start), 0);
    chk("rst_frame_count", 32'(bus.o_frame_count), 0);
    chk("rst_pending", 32'(bus.o_cfg_pending), 0);
    chk("rst_error", 32'(bus.o_cfg_error), 0);
    chk("rst_state", 32'(bus.o_dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Default mode, frame 0
    chk_pix(0, 0, 3'b110);
    chk("first_line_start", 32'(bus.o_line_start), 1);
    chk("first_frame_start", 32'(bus.o_frame_start), 1);
    chk("run_state", 32'(bus.o_dbg_state), 1);
    wait_xy(1023, 0, 2000);  chk_pix(1023, 0, 3'b110);
    step();                  chk_pix(1024, 0, 3'b010);
    wait_xy(1071, 0, 2000);  chk_pix(1071, 0, 3'b010);
    step();                  chk_pix(1072, 0, 3'b011);
    wait_xy(1103, 0, 2000);  chk_pix(1103, 0, 3'b011);
    step();                  chk_pix(1104, 0, 3'b010);
    wait_xy(1183, 0, 2000);
    step();                  chk_pix(0, 1, 3'b110);
    chk("line_start_y1", 32'(bus.o_line_start), 1);
    chk("frame_start_y1", 32'(bus.o_frame_start), 0);
    wait_xy(1023, 767, 1000000); chk_pix(1023, 767, 3'b110);
    step();                      chk_pix(1024, 767, 3'b010);
    wait_xy(0, 771, 10000);  chk_pix(0, 771, 3'b000);
    wait_xy(0, 774, 10000);  chk_pix(0, 774, 3'b000);
    wait_xy(0, 775, 10000);  chk_pix(0, 775, 3'b010);

    // Mid-frame load of the tiny mode: pending until frame end
    set_mode(8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b1);
    pulse_load();
    chk("mid_load_pending", 32'(bus.o_cfg_pending), 1);
    chk("mid_load_error", 32'(bus.o_cfg_error), 0);
    wait_xy(1183, 793, 30000);
    chk_pix(1183, 793, 3'b010);
    chk("pending_at_end", 32'(bus.o_cfg_pending), 1);
    chk("count_frame0", 32'(bus.o_frame_count), 0);
    step();

    // Tiny frame 1: walk every pixel
    chk("tiny_pending_clear", 32'(bus.o_cfg_pending), 0);
    chk("count_frame1", 32'(bus.o_frame_count), 1);
    for (int y = 0; y < 7; y++) begin
      for (int x = 0; x < 12; x++) begin
        chk_pix(x, y, {(x < 8 && y < 4), (y == 5), !(x >= 9 && x < 11)});
        chk("tiny_line_start", 32'(bus.o_line_start), 32'(x == 0));
        chk("tiny_frame_start", 32'(bus.o_frame_start), 32'(x == 0 && y == 0));
        if (!(x == 11 && y == 6)) step();
      end
    end
    step();
    chk_pix(0, 0, 3'b101);
    chk("count_frame2", 32'(bus.o_frame_count), 2);

    // Rejected loads: zero hsync, then oversized vertical total
    set_mode(8, 1, 0, 1, 4, 1, 1, 1, 1'b1, 1'b0);
    pulse_load();
    chk("err_hsync0", 32'(bus.o_cfg_error), 1);
    chk("err_hsync0_pending", 32'(bus.o_cfg_pending), 0);
    step();
    chk("err_pulse_one_cycle", 32'(bus.o_cfg_error), 0);
    set_mode(8, 1, 2, 1, 8000, 1, 1, 200, 1'b1, 1'b0);
    pulse_load();
    chk("err_vtotal", 32'(bus.o_cfg_error), 1);
    chk("err_vtotal_pending", 32'(bus.o_cfg_pending), 0);
    wait_xy(11, 0, 100);
    step();
    chk_pix(0, 1, 3'b101);

    // Load mode B on the exact frame-end cycle: applied directly
    wait_xy(11, 6, 100);
    chk("pre_end_pending", 32'(bus.o_cfg_pending), 0);
    set_mode(6, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b0);
    pulse_load();
    chk_pix(0, 0, 3'b110);
    chk("direct_pending", 32'(bus.o_cfg_pending), 0);
    chk("direct_frame_start", 32'(bus.o_frame_start), 1);
    chk("count_frame3", 32'(bus.o_frame_count), 3);
    wait_xy(7, 0, 20);  chk_pix(7, 0, 3'b011);
    step();             chk_pix(8, 0, 3'b010);
    step();             chk_pix(0, 1, 3'b110);

    // Two loads before frame end: only the second takes effect
    set_mode(20, 2, 2, 2, 10, 1, 1, 1, 1'b1, 1'b1);
    pulse_load();
    chk("two_load_pending1", 32'(bus.o_cfg_pending), 1);
    set_mode(8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b1);
    pulse_load();
    chk("two_load_pending2", 32'(bus.o_cfg_pending), 1);
    wait_xy(8, 5, 100);
    chk("two_load_pending_end", 32'(bus.o_cfg_pending), 1);
    step();
    chk_pix(0, 0, 3'b101);
    chk("count_frame4", 32'(bus.o_frame_count), 4);
    wait_xy(11, 0, 30);
    step();
    chk_pix(0, 1, 3'b101);

    // Minimal 2x2 mode for the frame counter wrap
    set_mode(1, 0, 1, 0, 1, 0, 1, 0, 1'b1, 1'b1);
    pulse_load();
    wait_xy(11, 6, 100);
    step();  chk_pix(0, 0, 3'b100);
    chk("count_frame5", 32'(bus.o_frame_count), 5);
    step();  chk_pix(1, 0, 3'b001);
    step();  chk_pix(0, 1, 3'b010);
    step();  chk_pix(1, 1, 3'b011);
    step();  chk_pix(0, 0, 3'b100);
    chk("count_frame6", 32'(bus.o_frame_count), 6);
    repeat ((65536 - 6) * 4 - 1) step();
    chk_pix(1, 1, 3'b011);
    chk("count_pre_wrap", 32'(bus.o_frame_count), 65535);
    step();
    chk_pix(0, 0, 3'b100);
    chk("count_wrap", 32'(bus.o_frame_count), 0);
    chk("wrap_frame_start", 32'(bus.o_frame_start), 1);

    // Back to tiny, leave a pending load, then async reset with the clock stopped
    set_mode(8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b1);
    pulse_load();
    wait_xy(1, 1, 10);
    step();
    chk_pix(0, 0, 3'b101);
    chk("count_after_wrap", 32'(bus.o_frame_count), 1);
    wait_xy(0, 1, 20);
    set_mode(6, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b0);
    pulse_load();
    chk("pre_reset_pending", 32'(bus.o_cfg_pending), 1);
    wait_xy(5, 3, 60);
    chk_pix(5, 3, 3'b101);
    clk_en = 1'b0;
    #4;
    rst = 1'b1;
    #1;
    chk_pix(0, 0, 3'b010);
    chk("async_line_start", 32'(bus.o_line_start), 0);
    chk("async_frame_start", 32'(bus.o_frame_start), 0);
    chk("async_frame_count", 32'(bus.o_frame_count), 0);
    chk("async_pending", 32'(bus.o_cfg_pending), 0);
    chk("async_state", 32'(bus.o_dbg_state), 0);
    #3;
    rst = 1'b0;
    #2;
    clk_en = 1'b1;
    step();
    chk_pix(0, 0, 3'b110);
    chk("restart_frame_start", 32'(bus.o_frame_start), 1);
    chk("restart_pending", 32'(bus.o_cfg_pending), 0);
    wait_xy(1183, 0, 2000);
    chk_pix(1183, 0, 3'b010);
    step();
    chk_pix(0, 1, 3'b110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
